// File: rtl/mem_block_copier.sv
// Block-copy engine: sole master of a 1024x32 data memory. Copies LENGTH
// words from SRC to DST in ascending order, optionally XOR-masking each
// word with {key,key}. Three cycles per word (RD, CAP, WR); every output
// is driven straight from a register.
module mem_block_copier #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 11
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [LEN_W-1:0]    length,
  input  logic                xor_en,
  input  logic [DATA_W/2-1:0] key_in,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [LEN_W-1:0]    words_copied,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_write_data,
  output logic                mem_write,
  input  logic [DATA_W-1:0]   mem_read_data,
  output logic [2:0]          dbg_state
);

  // Largest legal length: one full pass over the address space.
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2**ADDR_W);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     src_q, src_d;
  logic [ADDR_W-1:0]     dst_q, dst_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic                  xor_q, xor_d;
  logic [DATA_W/2-1:0]   key_q, key_d;
  logic [LEN_W-1:0]      idx_q, idx_d;
  logic [LEN_W-1:0]      wc_q, wc_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [LEN_W-1:0]      idx_inc;
  logic [DATA_W-1:0]     mask;

  assign idx_inc = idx_q + LEN_W'(1);
  assign mask    = {key_q, key_q} & {DATA_W{xor_q}};

  // The read-data register doubles as the write-data register: it is loaded
  // at the end of CAP and presented to the memory throughout WR.
  // Outputs are registered alongside the state, so they describe the state
  // the FSM is in during the same cycle.

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      xor_q   <= 1'b0;
      key_q   <= '0;
      idx_q   <= '0;
      wc_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      xor_q   <= xor_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      wc_q    <= wc_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic and the next value of every registered output.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    xor_d   = xor_q;
    key_d   = key_q;
    idx_d   = idx_q;
    wc_d    = wc_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d = src_addr;
          dst_d = dst_addr;
          len_d = length;
          xor_d = xor_en;
          key_d = key_in;
          idx_d = '0;
          wc_d  = '0;
          if (length == '0 || length > MAX_LEN) begin
            // Nothing to move: report completion (and error if illegal).
            state_d = S_FIN;
            done_d  = 1'b1;
            err_d   = (length > MAX_LEN);
          end else begin
            state_d = S_RD;
            busy_d  = 1'b1;
            addr_d  = src_addr;
          end
        end
      end
      S_RD: begin
        // Memory samples the source address at the end of this cycle.
        state_d = S_CAP;
        busy_d  = 1'b1;
      end
      S_CAP: begin
        // Read data is valid now; capture it and set up the write.
        state_d = S_WR;
        busy_d  = 1'b1;
        we_d    = 1'b1;
        addr_d  = dst_q + idx_q[ADDR_W-1:0];
        wdata_d = mem_read_data ^ mask;
      end
      S_WR: begin
        idx_d = idx_inc;
        wc_d  = wc_q + LEN_W'(1);
        if (idx_inc == len_q) begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end else begin
          state_d = S_RD;
          busy_d  = 1'b1;
          addr_d  = src_q + idx_inc[ADDR_W-1:0];
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = err_q;
  assign words_copied   = wc_q;
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_write      = we_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_mem_block_copier.sv
// Directed bench for mem_block_copier with a behavioural 1024x32 memory.
// Expected memory writes are queued as {addr,data} and popped by a monitor.
module tb_mem_block_copier;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [9:0]  src_addr;
  logic [9:0]  dst_addr;
  logic [10:0] length;
  logic        xor_en;
  logic [15:0] key_in;
  logic        busy;
  logic        done;
  logic        error;
  logic [10:0] words_copied;
  logic [9:0]  mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic [31:0] mem_read_data;
  logic [2:0]  dbg_state;

  mem_block_copier #(.ADDR_W(10), .DATA_W(32), .LEN_W(11)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .src_addr       (src_addr),
    .dst_addr       (dst_addr),
    .length         (length),
    .xor_en         (xor_en),
    .key_in         (key_in),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .words_copied   (words_copied),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read_data  (mem_read_data),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [31:0] mem [0:1023];
  logic        pre_fill;
  logic        pre_we;
  logic [9:0]  pre_addr;
  logic [31:0] pre_data;

  always @(posedge clk) begin
    if (pre_fill) begin
      for (int k = 0; k < 1024; k++) mem[k] <= 32'hA500_0000 | 32'(k);
    end else if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (mem_write === 1'b1) begin
      mem[mem_address] <= mem_write_data;
    end
    mem_read_data <= mem[mem_address];
  end

  // ---------------- scoreboard ----------------
  int unsigned n_checks;
  int unsigned n_pass;
  int unsigned wr_cnt;
  int unsigned done_cnt;
  logic [41:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // Every write the DUT issues must match the head of the expected queue.
  always @(negedge clk) begin
    logic [41:0] e;
    if (mem_write === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("wr_unexpected_addr", {22'b0, mem_address}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {22'b0, mem_address}, {22'b0, e[41:32]});
        check("wr_data", mem_write_data, e[31:0]);
      end
    end
    if (done === 1'b1) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic fill_mem();
    @(negedge clk); pre_fill = 1'b1;
    @(negedge clk); pre_fill = 1'b0;
  endtask

  task automatic poke(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk); pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk); pre_we = 1'b0;
  endtask

  task automatic push_wr(input logic [9:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // Issue a command; lat = number of falling edges after the start sample
  // edge up to the one at which done is first seen high.
  task automatic run_cmd(input logic [9:0] s, input logic [9:0] d, input logic [10:0] n,
                         input logic x, input logic [15:0] k, input bit meddle,
                         output int lat, output logic err, output logic busy1);
    bit got;
    @(negedge clk);
    src_addr = s; dst_addr = d; length = n; xor_en = x; key_in = k; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble inputs: the running command must not see these.
    src_addr = ~s; dst_addr = ~d; length = 11'd3; xor_en = ~x; key_in = 16'hFFFF;
    lat = 0; err = 1'b0; busy1 = 1'b0; got = 1'b0;
    while (lat < 4000) begin
      @(negedge clk);
      lat++;
      if (lat == 1) busy1 = busy;
      if (meddle && lat == 3) begin
        src_addr = 10'h000; dst_addr = 10'h080; length = 11'd5; start = 1'b1;
      end
      if (meddle && lat == 4) start = 1'b0;
      if (done === 1'b1) begin
        err = error; got = 1'b1;
        break;
      end
    end
    if (!got) check("done_timeout", 32'd0, 32'd1);
    if (meddle) begin
      // Another start while in FIN.
      src_addr = 10'h000; dst_addr = 10'h080; length = 11'd5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  int          lat;
  logic        err;
  logic        b1;
  int unsigned w0;
  int unsigned d0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_pass = 0; wr_cnt = 0; done_cnt = 0;
    rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
    xor_en = 1'b0; key_in = '0; pre_fill = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_error", {31'b0, error}, 32'd0);
    check("rst_mem_write", {31'b0, mem_write}, 32'd0);
    check("rst_mem_address", {22'b0, mem_address}, 32'd0);
    check("rst_wdata", mem_write_data, 32'd0);
    check("rst_words_copied", {21'b0, words_copied}, 32'd0);
    check("rst_state", {29'b0, dbg_state}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // 1. Plain copy 0x010 -> 0x200, 4 words.
    fill_mem();
    for (int k = 0; k < 4; k++) push_wr(10'h200 + 10'(k), 32'hA500_0010 + 32'(k));
    w0 = wr_cnt;
    run_cmd(10'h010, 10'h200, 11'd4, 1'b0, 16'h0000, 1'b0, lat, err, b1);
    check("t1_latency", 32'(lat), 32'd13);
    check("t1_error", {31'b0, err}, 32'd0);
    check("t1_busy_first", {31'b0, b1}, 32'd1);
    check("t1_words_copied", {21'b0, words_copied}, 32'd4);
    check("t1_wr_count", wr_cnt - w0, 32'd4);
    repeat (3) @(negedge clk);
    check("t1_wc_hold", {21'b0, words_copied}, 32'd4);
    check("t1_busy_after", {31'b0, busy}, 32'd0);
    check("t1_q_empty", 32'(exp_q.size()), 32'd0);
    for (int k = 0; k < 4; k++) check("t1_mem", mem[10'h200 + 10'(k)], 32'hA500_0010 + 32'(k));

    // 4b. Illegal length 1025: done+error, no writes, count cleared.
    w0 = wr_cnt;
    run_cmd(10'h020, 10'h030, 11'd1025, 1'b0, 16'h0000, 1'b0, lat, err, b1);
    check("t4b_latency", 32'(lat), 32'd1);
    check("t4b_error", {31'b0, err}, 32'd1);
    check("t4b_words_copied", {21'b0, words_copied}, 32'd0);
    repeat (2) @(negedge clk);
    check("t4b_wr_count", wr_cnt - w0, 32'd0);
    check("t4b_error_pulse", {31'b0, error}, 32'd0);

    // 2. XOR copy of one word.
    fill_mem();
    poke(10'h005, 32'h1234_5678);
    push_wr(10'h006, 32'h1206_564A);
    run_cmd(10'h005, 10'h006, 11'd1, 1'b1, 16'h0032, 1'b0, lat, err, b1);
    check("t2_latency", 32'(lat), 32'd4);
    check("t2_words_copied", {21'b0, words_copied}, 32'd1);
    check("t2_mem_dst", mem[10'h006], 32'h1206_564A);
    check("t2_mem_src", mem[10'h005], 32'h1234_5678);
    check("t2_q_empty", 32'(exp_q.size()), 32'd0);

    // 3. Wrapping, overlapping copy: A,B,C -> A,A,A.
    fill_mem();
    poke(10'h3FE, 32'hAAAA_0001);
    poke(10'h3FF, 32'hBBBB_0002);
    poke(10'h000, 32'hCCCC_0003);
    push_wr(10'h3FF, 32'hAAAA_0001);
    push_wr(10'h000, 32'hAAAA_0001);
    push_wr(10'h001, 32'hAAAA_0001);
    run_cmd(10'h3FE, 10'h3FF, 11'd3, 1'b0, 16'h0000, 1'b0, lat, err, b1);
    check("t3_latency", 32'(lat), 32'd10);
    check("t3_mem_3ff", mem[10'h3FF], 32'hAAAA_0001);
    check("t3_mem_000", mem[10'h000], 32'hAAAA_0001);
    check("t3_mem_001", mem[10'h001], 32'hAAAA_0001);
    check("t3_mem_002", mem[10'h002], 32'hA500_0002);
    check("t3_q_empty", 32'(exp_q.size()), 32'd0);

    // 4a. Zero length.
    w0 = wr_cnt;
    run_cmd(10'h020, 10'h030, 11'd0, 1'b0, 16'h0000, 1'b0, lat, err, b1);
    check("t4a_latency", 32'(lat), 32'd1);
    check("t4a_error", {31'b0, err}, 32'd0);
    check("t4a_busy", {31'b0, b1}, 32'd0);
    check("t4a_words_copied", {21'b0, words_copied}, 32'd0);
    check("t4a_wr_count", wr_cnt - w0, 32'd0);

    // 4c. Full-memory copy onto itself.
    fill_mem();
    for (int k = 0; k < 1024; k++) push_wr(10'(k), 32'hA500_0000 | 32'(k));
    w0 = wr_cnt;
    run_cmd(10'h000, 10'h000, 11'd1024, 1'b0, 16'h0000, 1'b0, lat, err, b1);
    check("t4c_latency", 32'(lat), 32'd3073);
    check("t4c_error", {31'b0, err}, 32'd0);
    check("t4c_words_copied", {21'b0, words_copied}, 32'd1024);
    check("t4c_wr_count", wr_cnt - w0, 32'd1024);
    check("t4c_q_empty", 32'(exp_q.size()), 32'd0);

    // 5. Starts during busy and FIN are ignored.
    fill_mem();
    push_wr(10'h300, 32'hA500_0100);
    push_wr(10'h301, 32'hA500_0101);
    w0 = wr_cnt; d0 = done_cnt;
    run_cmd(10'h100, 10'h300, 11'd2, 1'b0, 16'h0000, 1'b1, lat, err, b1);
    check("t5_latency", 32'(lat), 32'd7);
    repeat (20) @(negedge clk);
    check("t5_done_count", done_cnt - d0, 32'd1);
    check("t5_wr_count", wr_cnt - w0, 32'd2);
    check("t5_busy", {31'b0, busy}, 32'd0);
    check("t5_words_copied", {21'b0, words_copied}, 32'd2);
    check("t5_mem_080", mem[10'h080], 32'hA500_0080);

    // 6. Reset in WR of word index 2 of an 8-word copy.
    fill_mem();
    for (int k = 0; k < 3; k++) push_wr(10'h100 + 10'(k), 32'hA500_0000 + 32'(k));
    @(negedge clk);
    src_addr = 10'h000; dst_addr = 10'h100; length = 11'd8; xor_en = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("t6_in_wr", {31'b0, mem_write}, 32'd1);
    check("t6_state_wr", {29'b0, dbg_state}, 32'd3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("t6_mem_write", {31'b0, mem_write}, 32'd0);
    check("t6_busy", {31'b0, busy}, 32'd0);
    check("t6_words_copied", {21'b0, words_copied}, 32'd0);
    check("t6_state", {29'b0, dbg_state}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    check("t6_q_empty", 32'(exp_q.size()), 32'd0);
    check("t6_mem_102", mem[10'h102], 32'hA500_0002);
    check("t6_mem_103", mem[10'h103], 32'hA500_0103);
    push_wr(10'h050, 32'hA500_0040);
    push_wr(10'h051, 32'hA500_0041);
    run_cmd(10'h040, 10'h050, 11'd2, 1'b0, 16'h0000, 1'b0, lat, err, b1);
    check("t6_new_latency", 32'(lat), 32'd7);
    check("t6_new_words_copied", {21'b0, words_copied}, 32'd2);
    repeat (2) @(negedge clk);
    check("t6_new_q_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
